// File: rtl/sort4_seq.sv
// Sequential 4-element sorter: captures four values, runs a 5-step compare-exchange
// network through one shared comparator, and reports ascending order plus a swap count.

module comparator #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] max,
    output logic [DATA_W-1:0] min
);

    always_comb begin
        if (a > b) begin
            max = a;
            min = b;
        end else begin
            max = b;
            min = a;
        end
    end

endmodule

module sort4_seq #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    input  logic [DATA_W-1:0] din2,
    input  logic [DATA_W-1:0] din3,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] dout0,
    output logic [DATA_W-1:0] dout1,
    output logic [DATA_W-1:0] dout2,
    output logic [DATA_W-1:0] dout3,
    output logic [2:0]        swap_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        SORT,
        DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [2:0]        step;
    logic [2:0]        cnt;
    logic [DATA_W-1:0] w [4];
    logic [1:0]        lo;
    logic [1:0]        hi;
    logic [DATA_W-1:0] cmp_a;
    logic [DATA_W-1:0] cmp_b;
    logic [DATA_W-1:0] cmp_max;
    logic [DATA_W-1:0] cmp_min;
    logic              swap;

    // Pair schedule of the 5-comparator sorting network, indexed by step.
    always_comb begin
        lo = 2'd0;
        hi = 2'd1;
        case (step)
            3'd0: begin lo = 2'd0; hi = 2'd1; end
            3'd1: begin lo = 2'd2; hi = 2'd3; end
            3'd2: begin lo = 2'd0; hi = 2'd2; end
            3'd3: begin lo = 2'd1; hi = 2'd3; end
            3'd4: begin lo = 2'd1; hi = 2'd2; end
            default: begin lo = 2'd0; hi = 2'd1; end
        endcase
    end

    assign cmp_a = w[lo];
    assign cmp_b = w[hi];

    comparator #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .a   (cmp_a),
        .b   (cmp_b),
        .max (cmp_max),
        .min (cmp_min)
    );

    // Equal elements leave the low slot unchanged, so they never count as a swap.
    assign swap = (cmp_min != cmp_a);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = SORT;
            SORT: if (step == 3'd4) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step     <= 3'd0;
            cnt      <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                w[i] <= '0;
            end
            dout0    <= '0;
            dout1    <= '0;
            dout2    <= '0;
            dout3    <= '0;
            swap_cnt <= 3'd0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        w[0] <= din0;
                        w[1] <= din1;
                        w[2] <= din2;
                        w[3] <= din3;
                        step <= 3'd0;
                        cnt  <= 3'd0;
                    end
                end
                SORT: begin
                    w[lo] <= cmp_min;
                    w[hi] <= cmp_max;
                    if (swap) begin
                        cnt <= cnt + 3'd1;
                    end
                    step <= step + 3'd1;
                end
                DONE: begin
                    // Results only move here, so dout/swap_cnt hold between pulses.
                    dout0    <= w[0];
                    dout1    <= w[1];
                    dout2    <= w[2];
                    dout3    <= w[3];
                    swap_cnt <= cnt;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sort4_seq.sv
// Scoreboard bench for sort4_seq: expected results are queued when a sort is started
// and compared when done pulses.

module tb_sort4_seq;

    typedef struct packed {
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
        logic [2:0] sw;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] din0, din1, din2, din3;
    logic       busy;
    logic       done;
    logic [3:0] dout0, dout1, dout2, dout3;
    logic [2:0] swap_cnt;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    sort4_seq #(.DATA_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .din0     (din0),
        .din1     (din1),
        .din2     (din2),
        .din3     (din3),
        .busy     (busy),
        .done     (done),
        .dout0    (dout0),
        .dout1    (dout1),
        .dout2    (dout2),
        .dout3    (dout3),
        .swap_cnt (swap_cnt)
    );

    always #5 clk = ~clk;

    // Sorted values from a plain insertion sort; swap count from walking the network pairs.
    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b,
                                   input logic [3:0] c, input logic [3:0] e);
        logic [3:0] v [4];
        logic [3:0] s [4];
        logic [3:0] t;
        int lo [5] = '{0, 2, 0, 1, 1};
        int hi [5] = '{1, 3, 2, 3, 2};
        int sw = 0;
        exp_t r;
        v[0] = a; v[1] = b; v[2] = c; v[3] = e;
        for (int k = 0; k < 5; k++) begin
            if (v[lo[k]] > v[hi[k]]) begin
                t = v[lo[k]]; v[lo[k]] = v[hi[k]]; v[hi[k]] = t;
                sw++;
            end
        end
        s[0] = a; s[1] = b; s[2] = c; s[3] = e;
        for (int i = 1; i < 4; i++) begin
            for (int j = i; j > 0; j--) begin
                if (s[j-1] > s[j]) begin
                    t = s[j-1]; s[j-1] = s[j]; s[j] = t;
                end
            end
        end
        r.d0 = s[0]; r.d1 = s[1]; r.d2 = s[2]; r.d3 = s[3];
        r.sw = sw[2:0];
        return r;
    endfunction

    function automatic exp_t observed();
        exp_t r;
        r.d0 = dout0; r.d1 = dout1; r.d2 = dout2; r.d3 = dout3;
        r.sw = swap_cnt;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_sort(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] e);
        din0 = a; din1 = b; din2 = c; din3 = e;
        start = 1'b1;
        q.push_back(model(a, b, c, e));
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        din0 = 4'd0; din1 = 4'd0; din2 = 4'd0; din3 = 4'd0;
        tick();
        tick();
        rst = 1'b0;
        n_vec++;
        if (observed() !== 19'd0 || done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got dout/swap=%h done=%b busy=%b, expected 0 0 0",
                     observed(), done, busy);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++;
            if (observed() !== 19'd0 || done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL idle_no_start cycle %0d: got dout/swap=%h done=%b busy=%b, expected 0 0 0",
                         i, observed(), done, busy);
            end
        end
    endtask

    task automatic test_basic();
        exp_t e;
        int   early = 0;
        start_sort(4'd12, 4'd8, 4'd13, 4'd10);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_accept: got %b, expected 1", busy);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done !== 1'b0) early++;
        end
        n_vec++;
        if (early != 0) begin
            n_err++;
            $display("FAIL done_too_early: got %0d early pulses, expected 0", early);
        end
        tick();
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL done_latency: got done=%b busy=%b, expected done=1 busy=0", done, busy);
        end
        e = q.pop_front();
        n_vec++;
        if (observed() !== e) begin
            n_err++;
            $display("FAIL basic_result: got %h, expected %h", observed(), e);
        end
        n_vec++;
        if (observed() !== {4'd13, 4'd12, 4'd10, 4'd8, 3'd3}) begin
            n_err++;
            $display("FAIL basic_literal: got %h, expected %h", observed(),
                     {4'd13, 4'd12, 4'd10, 4'd8, 3'd3});
        end
        tick();
        n_vec++;
        if (done !== 1'b0 || observed() !== e) begin
            n_err++;
            $display("FAIL done_one_cycle: got done=%b result=%h, expected done=0 result=%h",
                     done, observed(), e);
        end
    endtask

    task automatic test_boundary();
        int   vin [4][4] = '{'{1, 2, 3, 4}, '{15, 14, 13, 0}, '{7, 3, 7, 3}, '{5, 5, 5, 5}};
        exp_t lit [4];
        exp_t e;
        bit   ok;
        lit[0] = {4'd4, 4'd3, 4'd2, 4'd1, 3'd0};
        lit[1] = {4'd15, 4'd14, 4'd13, 4'd0, 3'd4};
        lit[2] = {4'd7, 4'd7, 4'd3, 4'd3, 3'd3};
        lit[3] = {4'd5, 4'd5, 4'd5, 4'd5, 3'd0};
        for (int k = 0; k < 4; k++) begin
            start_sort(4'(vin[k][0]), 4'(vin[k][1]), 4'(vin[k][2]), 4'(vin[k][3]));
            wait_done(ok);
            e = q.pop_front();
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL boundary_%0d timeout: got no done, expected done", k);
            end else if (observed() !== e || observed() !== lit[k]) begin
                n_err++;
                $display("FAIL boundary_%0d: got %h, expected %h", k, observed(), lit[k]);
            end
            tick();
        end
    endtask

    task automatic test_busy_protect();
        exp_t e;
        exp_t got = '0;
        int   pulses = 0;
        start_sort(4'd9, 4'd1, 4'd4, 4'd2);
        tick();
        din0 = 4'd0; din1 = 4'd0; din2 = 4'd0; din3 = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done === 1'b1) begin
                pulses++;
                got = observed();
            end
        end
        e = q.pop_front();
        n_vec++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL busy_single_done: got %0d pulses, expected 1", pulses);
        end
        n_vec++;
        if (got !== e || got !== {4'd9, 4'd4, 4'd2, 4'd1, 3'd4}) begin
            n_err++;
            $display("FAIL busy_result: got %h, expected %h", got, e);
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        bit   ok;
        int   pulses = 0;
        start_sort(4'd12, 4'd8, 4'd13, 4'd10);
        tick();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        void'(q.pop_back());
        n_vec++;
        if (observed() !== 19'd0 || done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_clear: got dout/swap=%h done=%b busy=%b, expected 0 0 0",
                     observed(), done, busy);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done !== 1'b0 || observed() !== 19'd0) pulses++;
        end
        n_vec++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL mid_reset_no_done: got %0d bad cycles, expected 0", pulses);
        end
        start_sort(4'd3, 4'd2, 4'd1, 4'd0);
        wait_done(ok);
        e = q.pop_front();
        n_vec++;
        if (!ok || observed() !== e || observed() !== {4'd3, 4'd2, 4'd1, 4'd0, 3'd4}) begin
            n_err++;
            $display("FAIL after_reset_sort: got %h done_seen=%b, expected %h", observed(), ok, e);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_t first = '0;
        int   t1 = -1;
        int   t2 = -1;
        din0 = 4'd4; din1 = 4'd3; din2 = 4'd2; din3 = 4'd1;
        start = 1'b1;
        q.push_back(model(4'd4, 4'd3, 4'd2, 4'd1));
        tick();
        din0 = 4'd8; din1 = 4'd8; din2 = 4'd0; din3 = 4'd15;
        q.push_back(model(4'd8, 4'd8, 4'd0, 4'd15));
        for (int i = 1; i <= 20 && t2 < 0; i++) begin
            tick();
            if (done === 1'b1) begin
                e = q.pop_front();
                n_vec++;
                if (observed() !== e) begin
                    n_err++;
                    $display("FAIL b2b_result: got %h, expected %h", observed(), e);
                end
                if (t1 < 0) begin
                    t1 = i;
                    first = observed();
                end else begin
                    t2 = i;
                    start = 1'b0;
                end
            end else if (t1 >= 0) begin
                n_vec++;
                if (observed() !== first) begin
                    n_err++;
                    $display("FAIL b2b_hold: got %h, expected %h", observed(), first);
                end
            end
        end
        start = 1'b0;
        n_vec++;
        if (t1 != 6 || t2 - t1 != 7) begin
            n_err++;
            $display("FAIL b2b_spacing: got first=%0d gap=%0d, expected first=6 gap=7", t1, t2 - t1);
        end
        n_vec++;
        if (first !== {4'd4, 4'd3, 4'd2, 4'd1, 3'd4} ||
            observed() !== {4'd15, 4'd8, 4'd8, 4'd0, 3'd1}) begin
            n_err++;
            $display("FAIL b2b_literal: got %h then %h, expected %h then %h", first, observed(),
                     {4'd4, 4'd3, 4'd2, 4'd1, 3'd4}, {4'd15, 4'd8, 4'd8, 4'd0, 3'd1});
        end
        q.delete();
        tick();
        tick();
    endtask

    task automatic test_random();
        exp_t e;
        bit   ok;
        for (int k = 0; k < 1000; k++) begin
            start_sort(4'($urandom_range(15)), 4'($urandom_range(15)),
                       4'($urandom_range(15)), 4'($urandom_range(15)));
            wait_done(ok);
            e = q.pop_front();
            n_vec++;
            if (!ok || observed() !== e) begin
                n_err++;
                $display("FAIL random_%0d: got %h done_seen=%b, expected %h", k, observed(), ok, e);
            end
            n_vec++;
            if (!(dout0 <= dout1 && dout1 <= dout2 && dout2 <= dout3)) begin
                n_err++;
                $display("FAIL random_order_%0d: got %0d %0d %0d %0d, expected non-decreasing",
                         k, dout0, dout1, dout2, dout3);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_busy_protect();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
